// File: rtl/mod47_div.sv
// Sequential modular divider over GF(MOD): q = a * b^-1 mod MOD, with b^-1 = b^(MOD-2)
// computed by left-to-right square-and-multiply, then one final multiply by a.
module mod47_div #(
    parameter int MOD = 47,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_q,
    output logic         out_err
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and out_valid/out_q/out_err hold until transferred.

    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam logic [2*W-1:0] MOD_P = (2*W)'(MOD);
    localparam logic [W:0]     MOD_W = (W+1)'(MOD);
    localparam logic [W-1:0]   EXP_E = W'(MOD - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXP  = 2'd1,
        S_MULA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   r_q, r_d;
    logic [KW-1:0]  k_q, k_d;
    logic [W-1:0]   q_q, q_d;
    logic           err_q, err_d;

    function automatic logic [W-1:0] modmul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        logic [2*W-1:0] m;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        m = p % MOD_P;
        return m[W-1:0];
    endfunction

    logic [W-1:0] sq;
    logic [W-1:0] sq_b;
    logic [W-1:0] r_a;
    logic         bad_ops;

    // Square and square-times-b are chained in the same cycle.
    assign sq      = modmul(r_q, r_q);
    assign sq_b    = modmul(sq, b_q);
    assign r_a     = modmul(r_q, a_q);
    assign bad_ops = (in_b == '0) || ({1'b0, in_a} >= MOD_W) || ({1'b0, in_b} >= MOD_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            k_q     <= k_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        k_d     = k_q;
        q_d     = q_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    r_d = W'(1);
                    k_d = KW'(W - 1);
                    q_d = '0;
                    if (bad_ops) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_EXP;
                    end
                end
            end
            S_EXP: begin
                r_d = EXP_E[k_q] ? sq_b : sq;
                if (k_q == '0) begin
                    state_d = S_MULA;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            S_MULA: begin
                r_d     = r_a;
                q_d     = r_a;
                err_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_q     = q_q;
    assign out_err   = err_q;

endmodule
